// File: rtl/execute_stage.sv
// Execute stage of the mriscv RV32I pipeline.
// Resolves ALU operations, load/store effective addresses, branch conditions
// and jump targets. Result, next PC and destination index are registered,
// so each instruction appears on the outputs one cycle after it is presented.
// Decode flag precedence: jump > branch > load/store > ALU > bubble.

module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_store,
    input  logic        is_load,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic        is_reg,
    input  logic        is_alu,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] branch_dest,
    input  logic [4:0]  dest_i,
    output logic [4:0]  dest_o,
    input  logic [2:0]  func3,
    input  logic        func7,
    output logic [31:0] result,
    input  logic [31:0] curr_pc,
    output logic [31:0] next_pc
);

    // Branch condition evaluation; funct3 010/011 are not branch encodings
    // and never take.
    function automatic logic branch_taken(
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic taken;
        case (f3)
            3'b000:  taken = (a == b);
            3'b001:  taken = (a != b);
            3'b100:  taken = ($signed(a) <  $signed(b));
            3'b101:  taken = ($signed(a) >= $signed(b));
            3'b110:  taken = (a <  b);
            3'b111:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // RV32I integer ALU; SUB only exists in register-register form, while
    // SRA is selected by funct7 for both SRAI and SRA.
    function automatic logic [31:0] alu_op(
        input logic [2:0]  f3,
        input logic        f7,
        input logic        reg_form,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] res;
        logic [4:0]  shamt;
        shamt = b[4:0];
        case (f3)
            3'b000: begin
                if (reg_form && f7) begin
                    res = a - b;
                end else begin
                    res = a + b;
                end
            end
            3'b001:  res = a << shamt;
            3'b010:  res = {31'd0, ($signed(a) < $signed(b))};
            3'b011:  res = {31'd0, (a < b)};
            3'b100:  res = a ^ b;
            3'b101: begin
                if (f7) begin
                    res = $unsigned($signed(a) >>> shamt);
                end else begin
                    res = a >> shamt;
                end
            end
            3'b110:  res = a | b;
            3'b111:  res = a & b;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    logic [31:0] result_d;
    logic [31:0] result_q;
    logic [31:0] next_pc_d;
    logic [31:0] next_pc_q;
    logic [4:0]  dest_d;
    logic [4:0]  dest_q;

    logic [31:0] seq_pc_s;
    logic [31:0] rel_target_s;
    logic [31:0] reg_sum_s;

    // Shared adders: sequential PC, PC-relative target, and rs1+offset used
    // both for JALR targets and load/store addresses.
    always_comb begin
        seq_pc_s     = curr_pc + 32'd4;
        rel_target_s = curr_pc + branch_dest;
        reg_sum_s    = operand_a + branch_dest;
    end

    // Next-state selection by instruction class in priority order.
    always_comb begin
        result_d  = 32'd0;
        next_pc_d = seq_pc_s;
        dest_d    = dest_i;
        if (is_jump) begin
            result_d = seq_pc_s;
            if (is_reg) begin
                next_pc_d = {reg_sum_s[31:1], 1'b0};
            end else begin
                next_pc_d = rel_target_s;
            end
        end else if (is_branch) begin
            result_d = 32'd0;
            if (branch_taken(func3, operand_a, operand_b)) begin
                next_pc_d = rel_target_s;
            end else begin
                next_pc_d = seq_pc_s;
            end
        end else if (is_load || is_store) begin
            result_d  = reg_sum_s;
            next_pc_d = seq_pc_s;
        end else if (is_alu) begin
            result_d  = alu_op(func3, func7, is_reg, operand_a, operand_b);
            next_pc_d = seq_pc_s;
        end else begin
            result_d  = 32'd0;
            next_pc_d = seq_pc_s;
        end
    end

    // Output registers; asynchronous clear so a reset mid-stream flushes at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q  <= 32'd0;
            next_pc_q <= 32'd0;
            dest_q    <= 5'd0;
        end else begin
            result_q  <= result_d;
            next_pc_q <= next_pc_d;
            dest_q    <= dest_d;
        end
    end

    assign result  = result_q;
    assign next_pc = next_pc_q;
    assign dest_o  = dest_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage with hand-computed expectations.

module tb_execute_stage;

    logic        clk;
    logic        reset;
    logic        is_store;
    logic        is_load;
    logic        is_branch;
    logic        is_jump;
    logic        is_reg;
    logic        is_alu;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] branch_dest;
    logic [4:0]  dest_i;
    logic [4:0]  dest_o;
    logic [2:0]  func3;
    logic        func7;
    logic [31:0] result;
    logic [31:0] curr_pc;
    logic [31:0] next_pc;

    int total_cnt;
    int bad_cnt;

    execute_stage dut (
        .clk         (clk),
        .reset       (reset),
        .is_store    (is_store),
        .is_load     (is_load),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .is_reg      (is_reg),
        .is_alu      (is_alu),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .branch_dest (branch_dest),
        .dest_i      (dest_i),
        .dest_o      (dest_o),
        .func3       (func3),
        .func7       (func7),
        .result      (result),
        .curr_pc     (curr_pc),
        .next_pc     (next_pc)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (obs !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // flags = {jump, branch, load, store, alu, reg}
    task automatic set_in(input logic [5:0] flags, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] bd,
                          input logic [31:0] pc, input logic [4:0] dst);
        {is_jump, is_branch, is_load, is_store, is_alu, is_reg} = flags;
        func3       = f3;
        func7       = f7;
        operand_a   = a;
        operand_b   = b;
        branch_dest = bd;
        curr_pc     = pc;
        dest_i      = dst;
    endtask

    task automatic step_check(input string tag, input logic [31:0] exp_res,
                              input logic [31:0] exp_pc, input logic [4:0] exp_dst);
        @(posedge clk);
        #1;
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_next_pc"}, next_pc, exp_pc);
        check_eq({tag, "_dest"}, {27'd0, dest_o}, {27'd0, exp_dst});
    endtask

    task automatic run(input string tag, input logic [5:0] flags, input logic [2:0] f3,
                       input logic f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] bd, input logic [31:0] pc, input logic [4:0] dst,
                       input logic [31:0] exp_res, input logic [31:0] exp_pc);
        set_in(flags, f3, f7, a, b, bd, pc, dst);
        step_check(tag, exp_res, exp_pc, dst);
    endtask

    localparam logic [5:0] F_JAL  = 6'b100000;
    localparam logic [5:0] F_JALR = 6'b100001;
    localparam logic [5:0] F_BR   = 6'b010000;
    localparam logic [5:0] F_LD   = 6'b001000;
    localparam logic [5:0] F_ST   = 6'b000100;
    localparam logic [5:0] F_ALUI = 6'b000010;
    localparam logic [5:0] F_ALUR = 6'b000011;
    localparam logic [5:0] F_NONE = 6'b000000;

    // Directed stimulus sequence.
    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        set_in(F_NONE, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_next_pc", next_pc, 32'd0);
        check_eq("rst_dest", {27'd0, dest_o}, 32'd0);
        #9;
        reset = 1'b1;

        // Branches
        run("beq_taken",   F_BR, 3'b000, 1'b0, 32'd200, 32'd200, 32'd20, 32'd20, 5'd10, 32'd0, 32'd40);
        run("blt_signed",  F_BR, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'd100, 5'd1, 32'd0, 32'd92);
        run("bltu_unsig",  F_BR, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'd100, 5'd2, 32'd0, 32'd104);
        run("bne_equal",   F_BR, 3'b001, 1'b0, 32'd5, 32'd5, 32'd64, 32'd100, 5'd3, 32'd0, 32'd104);
        run("bge_minneg",  F_BR, 3'b101, 1'b0, 32'h8000_0000, 32'd0, 32'd64, 32'd100, 5'd4, 32'd0, 32'd104);
        run("bgeu_big",    F_BR, 3'b111, 1'b0, 32'h8000_0000, 32'd0, 32'd64, 32'd100, 5'd5, 32'd0, 32'd164);
        run("br_f3_010",   F_BR, 3'b010, 1'b0, 32'd9, 32'd9, 32'd64, 32'd100, 5'd6, 32'd0, 32'd104);

        // ALU
        run("alu_add",     F_ALUR, 3'b000, 1'b0, 32'd7, 32'd5, 32'd0, 32'h40, 5'd7, 32'd12, 32'h44);
        run("alu_sub",     F_ALUR, 3'b000, 1'b1, 32'd7, 32'd5, 32'd0, 32'h44, 5'd8, 32'd2, 32'h48);
        run("alu_addi_f7", F_ALUI, 3'b000, 1'b1, 32'd7, 32'd5, 32'd0, 32'h48, 5'd9, 32'd12, 32'h4C);
        run("alu_sra",     F_ALUR, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'h4C, 5'd11, 32'hF800_0000, 32'h50);
        run("alu_srl",     F_ALUR, 3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'h50, 5'd12, 32'h0800_0000, 32'h54);
        run("alu_sll",     F_ALUI, 3'b001, 1'b0, 32'd1, 32'd33, 32'd0, 32'h54, 5'd13, 32'd2, 32'h58);
        run("alu_slt",     F_ALUR, 3'b010, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 32'h58, 5'd14, 32'd1, 32'h5C);
        run("alu_sltu",    F_ALUR, 3'b011, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 32'h5C, 5'd15, 32'd0, 32'h60);
        run("alu_xor",     F_ALUR, 3'b100, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'h60, 5'd16, 32'hFF00, 32'h64);
        run("alu_or",      F_ALUR, 3'b110, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'h64, 5'd17, 32'hFFF0, 32'h68);
        run("alu_and",     F_ALUR, 3'b111, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'h68, 5'd18, 32'h00F0, 32'h6C);

        // Jumps, memory address, priority, bubble
        run("jalr",        F_JALR, 3'b000, 1'b0, 32'h1001, 32'd0, 32'd4, 32'h200, 5'd19, 32'h204, 32'h1004);
        run("jal",         F_JAL, 3'b000, 1'b0, 32'h1001, 32'd0, 32'h100, 32'h200, 5'd20, 32'h204, 32'h300);
        run("load_addr",   F_LD, 3'b010, 1'b0, 32'h100, 32'd0, 32'hFFFF_FFFC, 32'd8, 5'd21, 32'hFC, 32'd12);
        run("store_addr",  F_ST, 3'b010, 1'b0, 32'h10, 32'd3, 32'd8, 32'd16, 5'd0, 32'h18, 32'd20);
        run("prio_jump",   6'b110010, 3'b000, 1'b0, 32'd1, 32'd1, 32'h20, 32'h10, 5'd22, 32'h14, 32'h30);
        run("prio_branch", 6'b011000, 3'b001, 1'b0, 32'd1, 32'd1, 32'h20, 32'h10, 5'd23, 32'd0, 32'h14);
        run("prio_ldalu",  6'b001010, 3'b000, 1'b0, 32'd1, 32'd1, 32'h20, 32'h10, 5'd24, 32'h21, 32'h14);
        run("bubble_wrap", F_NONE, 3'b000, 1'b0, 32'd1, 32'd1, 32'h20, 32'hFFFF_FFFC, 5'd25, 32'd0, 32'd0);

        // Reset in the middle of operation, then reload on the first edge after release
        run("pre_reset",   F_ALUR, 3'b000, 1'b0, 32'd100, 32'd23, 32'd0, 32'h80, 5'd31, 32'd123, 32'h84);
        #2;
        reset = 1'b0;
        #1;
        check_eq("midrst_result", result, 32'd0);
        check_eq("midrst_next_pc", next_pc, 32'd0);
        check_eq("midrst_dest", {27'd0, dest_o}, 32'd0);
        set_in(F_JAL, 3'b000, 1'b0, 32'd0, 32'd0, 32'h8, 32'h1000, 5'd26);
        #2;
        reset = 1'b1;
        step_check("post_rst", 32'h1004, 32'h1008, 5'd26);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
